byter_uart_tx: RTL

Port-mapped serial transmitter that sits downstream of the byter core's output ports and upstream of its input ports. It consumes a data byte from one out_port and a control byte from another, buffers bytes in a small FIFO, and shifts them out as 8N1 UART frames. A status byte is fed back into an in_port so programs can poll it. The core has no write strobe, so a write is signalled by toggling a control bit.

---
 rtl/byter_uart_tx_pkg.sv | 37 +++
 rtl/byter_uart_tx_if.sv | 13 +
 rtl/byter_sync_fifo.sv | 46 ++++
 rtl/byter_uart_tx.sv | 98 +++++++++
 4 files changed

// File: rtl/byter_uart_tx_pkg.sv
// byter_uart_tx_pkg: shared status/control bit positions, FSM states and status packing
package byter_uart_tx_pkg;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_CNT_LSB = 3;
    localparam int ST_OVF     = 6;

    localparam int CTL_WR     = 0;
    localparam int CTL_OVFCLR = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    function automatic logic [7:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic [2:0] cnt,
        input logic       ovf
    );
        logic [7:0] s;
        s = '0;
        s[ST_FULL]                 = full;
        s[ST_EMPTY]                = empty;
        s[ST_BUSY]                 = busy;
        s[ST_CNT_LSB+2:ST_CNT_LSB] = cnt;
        s[ST_OVF]                  = ovf;
        return s;
    endfunction

endpackage

// File: rtl/byter_uart_tx_if.sv
// byter_uart_tx_if: port bundle between the byter core ports and the UART transmitter
//   tx_data : data byte from a core out_port
//   tx_ctrl : control byte from a core out_port (bit0 write toggle, bit1 overflow clear)
//   status  : status byte to a core in_port
//   tx      : serial line, idle high
interface byter_uart_tx_if;
    logic [7:0] tx_data;
    logic [7:0] tx_ctrl;
    logic [7:0] status;
    logic       tx;
    modport master (output tx_data, tx_ctrl, input status, tx);
    modport slave  (input tx_data, tx_ctrl, output status, tx);
endinterface

// File: rtl/byter_sync_fifo.sv
// byter_sync_fifo: small synchronous FIFO with show-ahead read and occupancy count
//   clk, reset : clock, asynchronous active-high reset
//   push/wr_data : enqueue (ignored when full unless popping in the same cycle)
//   pop/rd_data  : dequeue, rd_data is the current head (ignored when empty)
//   full, empty, count : occupancy flags and number of stored entries
module byter_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the head slot, which the write then reuses.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rptr];

    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wr_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= do_push ? (wptr == AW'(DEPTH - 1) ? '0 : wptr + 1'b1) : wptr;
            rptr  <= do_pop ? (rptr == AW'(DEPTH - 1) ? '0 : rptr + 1'b1) : rptr;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/byter_uart_tx.sv
// byter_uart_tx: port-mapped 8N1 UART transmitter with toggle-triggered writes and a byte FIFO
//   clk, reset : clock, asynchronous active-high reset
//   bus.tx_data : byte to queue when a write toggle is seen
//   bus.tx_ctrl : bit0 write toggle, bit1 overflow clear (level), bits7:2 ignored
//   bus.status  : bit0 full, bit1 empty, bit2 busy, bits5:3 count, bit6 overflow, bit7 zero
//   bus.tx      : serial output, idle high
module byter_uart_tx
    import byter_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input logic            clk,
    input logic            reset,
    byter_uart_tx_if.slave bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    tx_state_e     state, state_d;
    logic [BW-1:0] baud, baud_d;
    logic [2:0]    bit_cnt, bit_d;
    logic [7:0]    shift, shift_d, head;
    logic [CW-1:0] count;
    logic          tgl_q, ovf, wr_ev, pop, full, empty, last;
    logic          ctrl_unused;

    assign ctrl_unused = &bus.tx_ctrl[7:2];
    // The core has no write strobe: any change of the toggle bit is one write.
    assign wr_ev = bus.tx_ctrl[CTL_WR] != tgl_q;
    assign last  = baud == BW'(CLKS_PER_BIT - 1);

    byter_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_ev),
        .wr_data (bus.tx_data),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tgl_q   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_d;
            baud    <= baud_d;
            bit_cnt <= bit_d;
            shift   <= shift_d;
            tgl_q   <= bus.tx_ctrl[CTL_WR];
            ovf     <= wr_ev && full && !pop ? 1'b1 : bus.tx_ctrl[CTL_OVFCLR] ? 1'b0 : ovf;
        end

    always_comb begin
        state_d = state;
        baud_d  = last ? '0 : baud + 1'b1;
        bit_d   = bit_cnt;
        shift_d = shift;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = START;
                end
            end
            START: if (last) begin
                bit_d   = '0;
                state_d = DATA;
            end
            DATA: if (last) begin
                shift_d = shift >> 1;
                bit_d   = bit_cnt + 3'd1;
                state_d = bit_cnt == 3'd7 ? STOP : DATA;
            end
            STOP: if (last) begin
                // Chain straight into the next start bit so queued frames have no idle gap.
                pop     = !empty;
                shift_d = empty ? shift : head;
                state_d = empty ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx     = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    assign bus.status = pack_status(full, empty, state != IDLE, 3'(count), ovf);
endmodule
